// File: rtl/ex_mem_stage.sv
// ex_mem_stage: MIPS execute stage plus EX/MEM register; EX_MULT_EN adds a 32-cycle multiplier with HI/LO and stall.
module ex_mem_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [1:0]        wb_ctl,
  input  logic [2:0]        m_ctl,
  input  logic              regdst,
  input  logic              alusrc,
  input  logic [1:0]        aluop,
  input  logic [DATA_W-1:0] npc,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [DATA_W-1:0] s_extend,
  input  logic [REG_W-1:0]  instr_2016,
  input  logic [REG_W-1:0]  instr_1511,
  output logic              stall,
  output logic [1:0]        wb_ctlout,
  output logic [2:0]        m_ctlout,
  output logic [DATA_W-1:0] add_result,
  output logic [DATA_W-1:0] alu_result,
  output logic              zero,
  output logic [DATA_W-1:0] rdata2out,
  output logic [REG_W-1:0]  muxout
);
  logic [DATA_W-1:0] opb, alu, fres;
  logic [5:0] funct;
  logic mul_dec;
  assign opb = alusrc ? s_extend : rdata2;
  assign funct = s_extend[5:0];
`ifdef EX_MULT_EN
  localparam int CW = $clog2(DATA_W);
  localparam logic [0:0] IDLE = 1'b0, BUSY = 1'b1;
  logic [0:0] state;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] hi, lo, mplier;
  logic [2*DATA_W-1:0] mcand, prod, prod_nxt;
  logic last_cnt;
  assign mul_dec = aluop == 2'b10 && funct == 6'h18;
  assign last_cnt = cnt == CW'(DATA_W-1);
  assign prod_nxt = mplier[0] ? prod + mcand : prod;
  // The completion cycle is unstalled so the held mult entry retires exactly once.
  assign stall = !rst && !flush && (state == IDLE ? mul_dec : !last_cnt);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
      mplier <= '0;
      mcand <= '0;
      prod <= '0;
    end else if (state == IDLE) begin
      if (mul_dec && !flush) begin
        state <= BUSY;
        cnt <= '0;
        mcand <= {{DATA_W{1'b0}}, rdata1};
        mplier <= opb;
        prod <= '0;
      end
    end else if (flush) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      prod <= prod_nxt;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + CW'(1);
      if (last_cnt) begin
        {hi, lo} <= prod_nxt;
        state <= IDLE;
        cnt <= '0;
      end
    end
`else
  assign mul_dec = 1'b0;
  assign stall = 1'b0;
`endif
  always_comb begin
    fres = '0;
    case (funct)
      6'h20: fres = rdata1 + opb;
      6'h22: fres = rdata1 - opb;
      6'h24: fres = rdata1 & opb;
      6'h25: fres = rdata1 | opb;
      6'h2A: fres = DATA_W'($signed(rdata1) < $signed(opb));
`ifdef EX_MULT_EN
      6'h10: fres = hi;
      6'h12: fres = lo;
`endif
      default: fres = '0;
    endcase
  end
  assign alu = aluop == 2'b10 ? fres : aluop == 2'b01 ? rdata1 - opb : rdata1 + opb;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wb_ctlout <= '0;
      m_ctlout <= '0;
      add_result <= '0;
      alu_result <= '0;
      zero <= 1'b0;
      rdata2out <= '0;
      muxout <= '0;
    end else if (flush || stall) begin
      wb_ctlout <= '0;
      m_ctlout <= '0;
    end else begin
      wb_ctlout <= mul_dec ? '0 : wb_ctl;
      m_ctlout <= mul_dec ? '0 : m_ctl;
      add_result <= npc + (s_extend << 2);
      alu_result <= alu;
      zero <= alu == '0;
      rdata2out <= rdata2;
      muxout <= regdst ? instr_1511 : instr_2016;
    end
endmodule
